oak_const_streamer: RTL and testbench

OAK_CONST_STREAMER -- requirements
Module: oak_const_streamer

---
 rtl/oak_pkg.sv | 69 ++++++
 rtl/oak_xor_accum.sv | 36 +++
 rtl/oak_const_streamer.sv | 181 ++++++++++++++++++
 tb/tb_oak_const_streamer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oak_pkg.sv
// Shared frame constants, FSM state encoding and byte-selection helpers for the
// oak constant streamer. Frame layout: SYNC, 4-byte id, COUNT, four 8-byte
// doubles, checksum -- every multi-byte field most significant byte first.
package oak_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'h5A;
    localparam logic [7:0] COUNT_BYTE = 8'h04;
    localparam int         FRAME_LEN  = 39;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_ID   = 3'd2,
        ST_CNT  = 3'd3,
        ST_PAY  = 3'd4,
        ST_CSUM = 3'd5
    } state_e;

    // Everything captured when a frame is accepted.
    typedef struct packed {
        logic [31:0] id;
        logic [63:0] phi;
        logic [63:0] pi;
        logic [63:0] e;
        logic [63:0] trinity;
    } snap_t;

    // Byte idx of the node id, idx 0 = most significant.
    function automatic logic [7:0] id_byte(input logic [31:0] id, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = id[31:24];
            2'd1:    b = id[23:16];
            2'd2:    b = id[15:8];
            default: b = id[7:0];
        endcase
        return b;
    endfunction

    // Byte idx of a 64-bit word, idx 0 = most significant.
    function automatic logic [7:0] dword_byte(input logic [63:0] w, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = w[63:56];
            3'd1:    b = w[55:48];
            3'd2:    b = w[47:40];
            3'd3:    b = w[39:32];
            3'd4:    b = w[31:24];
            3'd5:    b = w[23:16];
            3'd6:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    // Payload byte: word selects phi/pi/e/trinity, idx selects the byte within it.
    function automatic logic [7:0] pay_byte(input snap_t s, input logic [1:0] word,
                                            input logic [2:0] idx);
        logic [63:0] w;
        case (word)
            2'd0:    w = s.phi;
            2'd1:    w = s.pi;
            2'd2:    w = s.e;
            default: w = s.trinity;
        endcase
        return dword_byte(w, idx);
    endfunction

endpackage

// File: rtl/oak_xor_accum.sv
// Purpose: 8-bit XOR accumulator with synchronous clear and enable.
// Latency: result visible one cycle after clr/en; clr has priority over en.
// Backpressure: none; the caller gates en with its own handshake.
// Ports: clk/rst (async active-high), clr, en, din[7:0] in; acc[7:0] out.
module oak_xor_accum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = 8'h00;
        end else if (en) begin
            acc_d = acc_q ^ din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 8'h00;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/oak_const_streamer.sv
// Purpose: streams one 39-byte frame (SYNC, id, COUNT, phi/pi/e/trinity, CSUM) per start.
// Latency: m_valid rises the cycle after an accepted start; 39 cycles per frame at full rate.
// Backpressure: valid/ready; m_data/m_last hold while m_ready is low, start ignored while busy.
// Ports: clk, rst (async active-high); phi/pi/e/trinity[63:0], phoenix_id[31:0], start in;
//        m_data[7:0], m_valid, m_last out, m_ready in; busy, done out.
module oak_const_streamer
    import oak_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] phi,
    input  logic [63:0] pi,
    input  logic [63:0] e,
    input  logic [63:0] trinity,
    input  logic [31:0] phoenix_id,
    input  logic        start,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic        done
);

    state_e      state_q,    state_d;
    snap_t       snap_q,     snap_d;
    logic [1:0]  id_cnt_q,   id_cnt_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [1:0]  word_cnt_q, word_cnt_d;
    logic [7:0]  m_data_q,   m_data_d;
    logic        m_valid_q,  m_valid_d;
    logic        m_last_q,   m_last_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;

    logic       hs;
    logic       accept;
    logic       csum_en;
    logic [7:0] csum;

    assign hs     = m_valid_q & m_ready;
    assign accept = start & ~busy_q;

    // Everything between SYNC and CSUM feeds the checksum; the byte being
    // handshaken is the registered one on m_data.
    assign csum_en = hs & ((state_q == ST_ID) | (state_q == ST_CNT) | (state_q == ST_PAY));

    oak_xor_accum u_csum (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (csum_en),
        .din (m_data_q),
        .acc (csum)
    );

    // Outputs are registered: on each handshake the byte for the following
    // position is computed here and loaded, so there are no bubbles at full rate.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        id_cnt_d   = id_cnt_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_SYNC;
                    snap_d     = '{id: phoenix_id, phi: phi, pi: pi, e: e, trinity: trinity};
                    id_cnt_d   = 2'd0;
                    byte_cnt_d = 3'd0;
                    word_cnt_d = 2'd0;
                    m_data_d   = SYNC_BYTE;
                    m_valid_d  = 1'b1;
                    m_last_d   = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_SYNC: begin
                if (hs) begin
                    state_d  = ST_ID;
                    m_data_d = id_byte(snap_q.id, 2'd0);
                end
            end
            ST_ID: begin
                if (hs) begin
                    if (id_cnt_q == 2'd3) begin
                        state_d  = ST_CNT;
                        id_cnt_d = 2'd0;
                        m_data_d = COUNT_BYTE;
                    end else begin
                        id_cnt_d = id_cnt_q + 2'd1;
                        m_data_d = id_byte(snap_q.id, id_cnt_q + 2'd1);
                    end
                end
            end
            ST_CNT: begin
                if (hs) begin
                    state_d  = ST_PAY;
                    m_data_d = pay_byte(snap_q, 2'd0, 3'd0);
                end
            end
            ST_PAY: begin
                if (hs) begin
                    if (byte_cnt_q == 3'd7) begin
                        byte_cnt_d = 3'd0;
                        if (word_cnt_q == 2'd3) begin
                            state_d    = ST_CSUM;
                            word_cnt_d = 2'd0;
                            // Fold in the last payload byte, which the
                            // accumulator only absorbs on this same edge.
                            m_data_d   = csum ^ m_data_q;
                            m_last_d   = 1'b1;
                        end else begin
                            word_cnt_d = word_cnt_q + 2'd1;
                            m_data_d   = pay_byte(snap_q, word_cnt_q + 2'd1, 3'd0);
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        m_data_d   = pay_byte(snap_q, word_cnt_q, byte_cnt_q + 3'd1);
                    end
                end
            end
            ST_CSUM: begin
                if (hs) begin
                    state_d   = ST_IDLE;
                    m_data_d  = 8'h00;
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            snap_q     <= '0;
            id_cnt_q   <= 2'd0;
            byte_cnt_q <= 3'd0;
            word_cnt_q <= 2'd0;
            m_data_q   <= 8'h00;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            id_cnt_q   <= id_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_oak_const_streamer.sv
// Purpose: self-checking bench for oak_const_streamer with a byte scoreboard.
// Latency: expected frames are queued at start; bytes checked on each handshake.
// Backpressure: m_ready driven high or pseudo-random; stalls checked for stability.
module tb_oak_const_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] phi, pi, e, trinity;
    logic [31:0] phoenix_id;
    logic        start;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic        done;

    oak_const_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .phi        (phi),
        .pi         (pi),
        .e          (e),
        .trinity    (trinity),
        .phoenix_id (phoenix_id),
        .start      (start),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard entries: {last, byte}.
    logic [8:0] exp_q[$];
    int         cyc = 0;
    int         hs_cnt = 0;
    int         last_hs_cyc = 0;
    int         done_cnt = 0;
    bit         exp_done = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] held_data;
    logic       held_last;
    bit         rand_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge: inputs change only just after rising edges,
    // so valid&ready seen here is the handshake of the next rising edge.
    always @(negedge clk) begin
        logic [8:0] ent;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (done || exp_done) begin
                chk("done_pulse", done, exp_done);
                if (exp_done) chk("busy_low_at_done", busy, 1'b0);
            end
            if (done) done_cnt++;
            exp_done = 1'b0;
            if (prev_stall) begin
                chk("stall_data", m_data, held_data);
                chk("stall_last", m_last, held_last);
            end
            prev_stall = m_valid && !m_ready;
            held_data  = m_data;
            held_last  = m_last;
            if (m_valid && m_ready) begin
                chk("hs_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    ent = exp_q.pop_front();
                    chk("byte", m_data, ent[7:0]);
                    chk("last", m_last, ent[8]);
                    if (ent[8]) exp_done = 1'b1;
                end
                hs_cnt++;
                last_hs_cyc = cyc;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rand_mode) m_ready = 1'($urandom_range(0, 1));
    endtask

    // Reference frame built from the current inputs.
    task automatic push_frame();
        logic [7:0]  b[39];
        logic [63:0] w[4];
        logic [7:0]  x;
        b[0] = 8'h5A;
        for (int i = 0; i < 4; i++) b[1+i] = 8'(phoenix_id >> (8 * (3 - i)));
        b[5] = 8'h04;
        w[0] = phi; w[1] = pi; w[2] = e; w[3] = trinity;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 8; i++)
                b[6 + 8*k + i] = 8'(w[k] >> (8 * (7 - i)));
        x = 8'h00;
        for (int i = 1; i <= 37; i++) x = x ^ b[i];
        b[38] = x;
        for (int i = 0; i < 39; i++) exp_q.push_back({(i == 38), b[i]});
    endtask

    task automatic set_foundation();
        phi        = 64'h3FF9E3779B97F4A8;
        pi         = 64'h400921FB54442D18;
        e          = 64'h4005BF0A8B145769;
        trinity    = 64'h4008000000000000;
        phoenix_id = 32'd999;
    endtask

    task automatic wait_frame_end(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, exp_q.size(), 0);
        cycle();
    endtask

    task automatic wait_hs(input string tag, input int target, input int budget);
        int n = 0;
        while (hs_cnt < target && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, hs_cnt >= target, 1'b1);
    endtask

    initial begin
        int h0, d0, t_start, n;

        rst = 1'b1; start = 1'b0; m_ready = 1'b1;
        phi = '0; pi = '0; e = '0; trinity = '0; phoenix_id = '0;
        repeat (3) cycle();
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_last",  m_last,  1'b0);
        chk("rst_busy",  busy,    1'b0);
        chk("rst_done",  done,    1'b0);
        chk("rst_data",  m_data,  8'h00);
        rst = 1'b0;
        repeat (2) cycle();

        // Full-rate foundation frame.
        set_foundation();
        chk("idle_valid", m_valid, 1'b0);
        push_frame();
        h0 = hs_cnt; d0 = done_cnt;
        start = 1'b1;
        cycle();
        start = 1'b0;
        t_start = cyc;
        chk("valid_latency", m_valid, 1'b1);
        chk("busy_set", busy, 1'b1);
        chk("first_sync", m_data, 8'h5A);
        wait_frame_end("t1_frame_end", 200);
        chk("t1_handshakes", hs_cnt - h0, 39);
        chk("t1_no_bubble", last_hs_cyc - t_start, 38);
        chk("t1_done_count", done_cnt - d0, 1);

        // Random backpressure.
        push_frame();
        h0 = hs_cnt; d0 = done_cnt;
        start = 1'b1;
        cycle();
        start = 1'b0;
        rand_mode = 1'b1;
        wait_frame_end("t2_frame_end", 3000);
        rand_mode = 1'b0;
        m_ready = 1'b1;
        cycle();
        chk("t2_handshakes", hs_cnt - h0, 39);
        chk("t2_done_count", done_cnt - d0, 1);

        // Start while busy, input change after acceptance.
        push_frame();
        h0 = hs_cnt; d0 = done_cnt;
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_hs("t3_reach_byte10", h0 + 9, 200);
        start = 1'b1;
        phi = 64'h0;
        cycle();
        start = 1'b0;
        chk("t3_busy_held", busy, 1'b1);
        wait_frame_end("t3_frame_end", 200);
        repeat (3) cycle();
        chk("t3_not_queued", m_valid, 1'b0);
        chk("t3_handshakes", hs_cnt - h0, 39);
        chk("t3_done_count", done_cnt - d0, 1);
        set_foundation();

        // Reset mid-frame.
        push_frame();
        h0 = hs_cnt; d0 = done_cnt;
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_hs("t4_reach_byte20", h0 + 19, 200);
        rst = 1'b1;
        #1;
        chk("t4_valid_drop", m_valid, 1'b0);
        chk("t4_busy_drop", busy, 1'b0);
        exp_q.delete();
        exp_done = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
        repeat (3) cycle();
        chk("t4_idle_after_rst", m_valid, 1'b0);
        chk("t4_no_done", done_cnt - d0, 0);
        push_frame();
        h0 = hs_cnt;
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("t4_restart_sync", m_data, 8'h5A);
        wait_frame_end("t4_frame_end", 200);
        chk("t4_handshakes", hs_cnt - h0, 39);

        // Start in the done cycle.
        push_frame();
        h0 = hs_cnt; d0 = done_cnt;
        start = 1'b1;
        cycle();
        start = 1'b0;
        t_start = cyc;
        n = 0;
        while (!done && n < 200) begin
            cycle();
            n++;
        end
        chk("t5_done_seen", done, 1'b1);
        chk("t5_busy_low", busy, 1'b0);
        push_frame();
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("t5_second_valid", m_valid, 1'b1);
        chk("t5_second_sync", m_data, 8'h5A);
        wait_frame_end("t5_frame_end", 200);
        chk("t5_handshakes", hs_cnt - h0, 78);
        chk("t5_span", last_hs_cyc - t_start, 78);
        chk("t5_done_count", done_cnt - d0, 2);

        repeat (2) cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
